eight_bit_serial_subtractor: RTL and testbench

//   Bit-serial 8-bit subtractor: diff = i0 - i1 - bin, one bit per clock, LSB first.

---
 rtl/eight_bit_serial_subtractor_if.sv | 23 ++
 rtl/eight_bit_serial_subtractor.sv | 89 ++++++++
 tb/tb_eight_bit_serial_subtractor.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/eight_bit_serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial subtractor.
interface eight_bit_serial_subtractor_if;
    logic       start;
    logic [7:0] i0;
    logic [7:0] i1;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       last_borrow;
    logic       overflow;
    logic       busy;
    logic       done;

    modport master (
        output start, i0, i1, bin,
        input  diff, bout, last_borrow, overflow, busy, done
    );

    modport slave (
        input  start, i0, i1, bin,
        output diff, bout, last_borrow, overflow, busy, done
    );
endinterface

// File: rtl/eight_bit_serial_subtractor.sv
// Bit-serial 8-bit subtractor: one full-subtractor cell plus a borrow flop, LSB first.
// Results publish only on the final bit, so diff never shows partial values.
module eight_bit_serial_subtractor (
    input  logic clk,
    input  logic rst,
    eight_bit_serial_subtractor_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for start; last result held on outputs
    // SUB   | shifting one bit per cycle through the subtractor cell
    // DONE  | one-cycle done pulse, results valid
    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t     state, state_nx;
    logic [7:0] a, b, part;
    logic [2:0] cnt;
    logic       br, lb_cand;
    logic [7:0] diff_q;
    logic       bout_q, lb_q, ovf_q;
    logic       d, br_nx;

    assign d     = a[0] ^ b[0] ^ br;
    assign br_nx = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = SUB;
            SUB:     if (cnt == 3'd7) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a       <= '0;
            b       <= '0;
            part    <= '0;
            cnt     <= '0;
            br      <= 1'b0;
            lb_cand <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            lb_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a   <= bus.i0;
                        b   <= bus.i1;
                        br  <= bus.bin;
                        cnt <= '0;
                    end
                end
                SUB: begin
                    a    <= {1'b0, a[7:1]};
                    b    <= {1'b0, b[7:1]};
                    part <= {d, part[7:1]};
                    br   <= br_nx;
                    // borrow out of bit 6 is the borrow into the sign bit
                    if (cnt == 3'd6) lb_cand <= br_nx;
                    if (cnt == 3'd7) begin
                        diff_q <= {d, part[7:1]};
                        bout_q <= br_nx;
                        lb_q   <= lb_cand;
                        ovf_q  <= br_nx ^ lb_cand;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.diff        = diff_q;
    assign bus.bout        = bout_q;
    assign bus.last_borrow = lb_q;
    assign bus.overflow    = ovf_q;
    assign bus.busy        = (state == SUB);
    assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_eight_bit_serial_subtractor.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops them on done.
module tb_eight_bit_serial_subtractor;
    typedef struct packed {
        logic [7:0] diff;
        logic       bout;
        logic       lb;
        logic       ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    res_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    eight_bit_serial_subtractor_if sif ();

    eight_bit_serial_subtractor dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sif.busy || sif.done) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic c);
        sif.start = 1'b1;
        sif.i0    = x;
        sif.i1    = y;
        sif.bin   = c;
    endtask

    task automatic run_op(input string name, input logic [7:0] x, input logic [7:0] y,
                          input logic c, input res_t r);
        wait_idle();
        issue(x, y, c);
        exp_q.push_back(r);
        tick();
        sif.start = 1'b0;
        chk({name, "_busy"}, sif.busy, 1);
        wait_idle();
    endtask

    task automatic monitor();
        res_t got, want;
        forever begin
            @(negedge clk);
            if (sif.done) begin
                got = '{sif.diff, sif.bout, sif.last_borrow, sif.overflow};
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    want = exp_q.pop_front();
                    chk("diff", got.diff, want.diff);
                    chk("bout", got.bout, want.bout);
                    chk("last_borrow", got.lb, want.lb);
                    chk("overflow", got.ovf, want.ovf);
                end
            end
        end
    endtask

    task automatic stimulus();
        int n, busy_cnt, done_cnt, first_done, second_done;
        sif.start = 1'b0;
        sif.i0    = '0;
        sif.i1    = '0;
        sif.bin   = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        chk("rst_diff", sif.diff, 0);
        chk("rst_flags", {sif.bout, sif.last_borrow, sif.overflow}, 0);
        chk("rst_busy_done", {sif.busy, sif.done}, 0);
        rst = 1'b0;
        tick();

        // T1 with latency measurement
        issue(8'h50, 8'h30, 1'b0);
        exp_q.push_back('{8'h20, 1'b0, 1'b0, 1'b0});
        n = 0;
        do begin
            tick();
            n++;
            sif.start = 1'b0;
        end while (!sif.done && n < 30);
        chk("t1_latency", n, 9);
        wait_idle();

        run_op("t2", 8'h30, 8'h50, 1'b0, '{8'hE0, 1'b1, 1'b1, 1'b0});
        run_op("t3", 8'h80, 8'h01, 1'b0, '{8'h7F, 1'b0, 1'b1, 1'b1});
        run_op("t4", 8'h00, 8'h00, 1'b1, '{8'hFF, 1'b1, 1'b1, 1'b0});
        run_op("ff_ff_b1", 8'hFF, 8'hFF, 1'b1, '{8'hFF, 1'b1, 1'b1, 1'b0});
        run_op("7f_ff", 8'h7F, 8'hFF, 1'b0, '{8'h80, 1'b1, 1'b0, 1'b1});

        // T5: start pulses during SUB cycles 3 and 8 must be ignored
        wait_idle();
        issue(8'h50, 8'h30, 1'b0);
        exp_q.push_back('{8'h20, 1'b0, 1'b0, 1'b0});
        busy_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (sif.busy) busy_cnt++;
            if (k == 1 || k == 4 || k == 9) sif.start = 1'b0;
            if (k == 3 || k == 8) issue(8'hFF, 8'h00, 1'b0);
            if (k == 1) chk("t5_diff_holds_prev", sif.diff, 8'h80);
        end
        chk("t5_busy_cycles", busy_cnt, 8);
        chk("t5_idle_after", {sif.busy, sif.done}, 0);

        // T6: reset mid-operation abandons the result
        issue(8'h30, 8'h50, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            sif.start = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy_done", {sif.busy, sif.done}, 0);
        chk("t6_diff", sif.diff, 0);
        chk("t6_bout", sif.bout, 0);
        done_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (sif.done) done_cnt++;
        end
        chk("t6_no_done", done_cnt, 0);
        run_op("t6_t3", 8'h80, 8'h01, 1'b0, '{8'h7F, 1'b0, 1'b1, 1'b1});

        // Continuous start: operations repeat every 10 cycles
        wait_idle();
        issue(8'h30, 8'h50, 1'b0);
        exp_q.push_back('{8'hE0, 1'b1, 1'b1, 1'b0});
        exp_q.push_back('{8'hE0, 1'b1, 1'b1, 1'b0});
        first_done = -1;
        second_done = -1;
        for (int k = 1; k <= 40 && second_done < 0; k++) begin
            tick();
            if (sif.done) begin
                if (first_done < 0) first_done = k;
                else begin
                    second_done = k;
                    sif.start = 1'b0;
                end
            end
        end
        chk("repeat_period", second_done - first_done, 10);
        sif.start = 1'b0;
        wait_idle();
        repeat (12) tick();
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
